// File: rtl/timer_pkg.sv
// Shared constants and helpers for the timer_counter_n core.
// The optional compare-match feature is selected with the TIMER_CMP_EN macro.
package timer_pkg;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Terminal count for a counter of the given width; callers cast to WIDTH bits.
    function automatic logic [63:0] max_count(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/timer_sticky_flag.sv
// One-bit sticky status flag: set dominates clear, async active-low reset.
module timer_sticky_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic flag
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= 1'b0;
        end else if (set) begin
            flag <= 1'b1;
        end else if (clr) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_counter_n.sv
// N-bit up/down timer with one-shot/auto-reload wrap and sticky status flags.
// Define TIMER_CMP_EN to enable the compare-match flag; otherwise cmp_match is held at 0.
module timer_counter_n
    import timer_pkg::*;
#(
    parameter int unsigned           WIDTH      = 8,
    parameter logic [WIDTH-1:0]      RST_RELOAD = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_ena,
    input  logic             enable,
    input  logic             up_down,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] start_counter,
    input  logic [WIDTH-1:0] compare_val,
    input  logic             clr_overflow,
    input  logic             clr_underflow,
    input  logic             clr_cmp,
    output logic [WIDTH-1:0] tcnt,
    output logic             running,
    output logic             overflow,
    output logic             underflow,
    output logic             cmp_match
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(max_count(WIDTH));

    logic [WIDTH-1:0] reload;
    logic             tick;
    logic             at_max;
    logic             at_zero;
    logic             ovf_set;
    logic             unf_set;
    logic             cmp_set;

    assign tick    = clk_ena & enable & running & ~load;
    assign at_max  = (tcnt == MAX_CNT);
    assign at_zero = (tcnt == '0);
    assign ovf_set = tick & (up_down == DIR_UP) & at_max;
    assign unf_set = tick & (up_down == DIR_DOWN) & at_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            reload  <= RST_RELOAD;
            running <= 1'b1;
        end else if (load) begin
            tcnt    <= start_counter;
            reload  <= start_counter;
            running <= 1'b1;
        end else if (tick) begin
            if (up_down == DIR_UP) begin
                if (!at_max) begin
                    tcnt <= tcnt + 1'b1;
                end else if (mode == MODE_RELOAD) begin
                    tcnt <= reload;
                end else begin
                    tcnt    <= '0;
                    running <= 1'b0;
                end
            end else begin
                if (!at_zero) begin
                    tcnt <= tcnt - 1'b1;
                end else if (mode == MODE_RELOAD) begin
                    tcnt <= reload;
                end else begin
                    tcnt    <= MAX_CNT;
                    running <= 1'b0;
                end
            end
        end
    end

`ifdef TIMER_CMP_EN
    // Compare the freshly updated count one cycle later so the match never
    // depends combinationally on the tick inputs.
    logic cnt_updated;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_updated <= 1'b0;
        end else begin
            cnt_updated <= load | tick;
        end
    end

    assign cmp_set = cnt_updated & (tcnt == compare_val);
`else
    logic unused_cmp;

    assign unused_cmp = ^compare_val;
    assign cmp_set    = 1'b0;
`endif

    timer_sticky_flag u_ovf_flag (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (ovf_set),
        .clr   (clr_overflow),
        .flag  (overflow)
    );

    timer_sticky_flag u_unf_flag (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (unf_set),
        .clr   (clr_underflow),
        .flag  (underflow)
    );

    timer_sticky_flag u_cmp_flag (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (cmp_set),
        .clr   (clr_cmp),
        .flag  (cmp_match)
    );

endmodule

// File: tb/tb_timer_counter_n.sv
// Self-checking bench for timer_counter_n: an 8-bit instance for counting/flags
// and a 16-bit instance for the compare-match feature (TIMER_CMP_EN aware).
module tb_timer_counter_n;

`ifdef TIMER_CMP_EN
    localparam logic CMP_ON = 1'b1;
`else
    localparam logic CMP_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] cnt;
        logic       run;
        logic       ov;
        logic       un;
    } s8_t;

    typedef struct packed {
        logic [15:0] cnt;
        logic        cm;
    } s16_t;

    logic clk;
    logic rst_n;

    logic       clk_ena, enable, up_down, mode, load;
    logic [7:0] start_counter, compare_val;
    logic       clr_overflow, clr_underflow, clr_cmp;
    logic [7:0] tcnt;
    logic       running, overflow, underflow, cmp_match;

    logic        clk_ena16, enable16, up_down16, mode16, load16;
    logic [15:0] start16, compare16;
    logic        clr_ovf16, clr_unf16, clr_cmp16;
    logic [15:0] tcnt16;
    logic        running16, overflow16, underflow16, cmp_match16;

    int total = 0;
    int bad   = 0;

    s8_t  q8[$];
    s16_t q16[$];

    timer_counter_n #(.WIDTH(8), .RST_RELOAD(8'h5A)) dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_ena       (clk_ena),
        .enable        (enable),
        .up_down       (up_down),
        .mode          (mode),
        .load          (load),
        .start_counter (start_counter),
        .compare_val   (compare_val),
        .clr_overflow  (clr_overflow),
        .clr_underflow (clr_underflow),
        .clr_cmp       (clr_cmp),
        .tcnt          (tcnt),
        .running       (running),
        .overflow      (overflow),
        .underflow     (underflow),
        .cmp_match     (cmp_match)
    );

    timer_counter_n #(.WIDTH(16)) dut16 (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_ena       (clk_ena16),
        .enable        (enable16),
        .up_down       (up_down16),
        .mode          (mode16),
        .load          (load16),
        .start_counter (start16),
        .compare_val   (compare16),
        .clr_overflow  (clr_ovf16),
        .clr_underflow (clr_unf16),
        .clr_cmp       (clr_cmp16),
        .tcnt          (tcnt16),
        .running       (running16),
        .overflow      (overflow16),
        .underflow     (underflow16),
        .cmp_match     (cmp_match16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s8_t e;
        s8_t o;
        rst_n = 1'b0;
        {clk_ena, enable, up_down, mode, load, clr_overflow, clr_underflow, clr_cmp} = '0;
        start_counter = '0;
        compare_val   = '0;
        {clk_ena16, enable16, up_down16, mode16, load16, clr_ovf16, clr_unf16, clr_cmp16} = '0;
        start16   = '0;
        compare16 = '0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        q8.push_back('{cnt: 8'h00, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e || cmp_match !== 1'b0) begin
            bad++;
            $display("FAIL reset8: got %h cm=%b want %h cm=0", o, cmp_match, e);
        end
        total++;
        if ({tcnt16, running16, overflow16, underflow16, cmp_match16} !== {16'h0000, 4'b1000}) begin
            bad++;
            $display("FAIL reset16: got cnt=%h run=%b ov=%b un=%b cm=%b", tcnt16, running16,
                     overflow16, underflow16, cmp_match16);
        end
    endtask

    task automatic test_down_oneshot();
        s8_t e;
        s8_t o;
        up_down = 1'b0;
        mode    = 1'b0;
        enable  = 1'b1;
        start_counter = 8'hFF;
        load = 1'b1;
        q8.push_back('{cnt: 8'hFF, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        load = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL dn_load: got %h want %h", o, e);
        end
        for (int i = 1; i <= 259; i++) begin
            if (i < 256) q8.push_back('{cnt: 8'(255 - i), run: 1'b1, ov: 1'b0, un: 1'b0});
            else         q8.push_back('{cnt: 8'hFF, run: 1'b0, ov: 1'b0, un: 1'b1});
            clk_ena = 1'b1;
            step();
            clk_ena = 1'b0;
            e = q8.pop_front();
            o = {tcnt, running, overflow, underflow};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL dn_tick%0d: got %h want %h", i, o, e);
            end
            step();
        end
    endtask

    task automatic test_flag_priority();
        s8_t e;
        s8_t o;
        clr_underflow = 1'b1;
        q8.push_back('{cnt: 8'hFF, run: 1'b0, ov: 1'b0, un: 1'b0});
        step();
        clr_underflow = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL clr_un: got %h want %h", o, e); end

        mode = 1'b1;
        start_counter = 8'h01;
        load = 1'b1;
        q8.push_back('{cnt: 8'h01, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        load = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL rearm: got %h want %h", o, e); end

        clk_ena = 1'b1;
        q8.push_back('{cnt: 8'h00, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL dn_to0: got %h want %h", o, e); end

        clr_underflow = 1'b1;
        q8.push_back('{cnt: 8'h01, run: 1'b1, ov: 1'b0, un: 1'b1});
        step();
        clk_ena = 1'b0;
        clr_underflow = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL set_beats_clr: got %h want %h", o, e); end

        q8.push_back('{cnt: 8'h01, run: 1'b1, ov: 1'b0, un: 1'b1});
        step();
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL sticky: got %h want %h", o, e); end

        clr_underflow = 1'b1;
        q8.push_back('{cnt: 8'h01, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        clr_underflow = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL clr_un2: got %h want %h", o, e); end
    endtask

    task automatic test_up_reload();
        s8_t e;
        s8_t o;
        int  r;
        up_down = 1'b1;
        mode    = 1'b1;
        start_counter = 8'd250;
        load = 1'b1;
        q8.push_back('{cnt: 8'd250, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        load = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL up_load: got %h want %h", o, e); end
        for (int k = 1; k <= 18; k++) begin
            r = k % 6;
            q8.push_back('{cnt: (r == 0) ? 8'd250 : 8'(250 + r), run: 1'b1,
                           ov: (k >= 6), un: 1'b0});
            clk_ena = 1'b1;
            step();
            clk_ena = 1'b0;
            e = q8.pop_front();
            o = {tcnt, running, overflow, underflow};
            total++;
            if (o !== e) begin bad++; $display("FAIL up_tick%0d: got %h want %h", k, o, e); end
            step();
        end
        clr_overflow = 1'b1;
        q8.push_back('{cnt: 8'd250, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        clr_overflow = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL clr_ov: got %h want %h", o, e); end
    endtask

    task automatic test_load_priority();
        s8_t e;
        s8_t o;
        start_counter = 8'h10;
        load    = 1'b1;
        clk_ena = 1'b1;
        q8.push_back('{cnt: 8'h10, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        load    = 1'b0;
        clk_ena = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL load_vs_tick: got %h want %h", o, e); end

        mode = 1'b0;
        start_counter = 8'hFF;
        load = 1'b1;
        q8.push_back('{cnt: 8'hFF, run: 1'b1, ov: 1'b0, un: 1'b0});
        step();
        load = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL load_ff: got %h want %h", o, e); end

        clk_ena = 1'b1;
        q8.push_back('{cnt: 8'h00, run: 1'b0, ov: 1'b1, un: 1'b0});
        step();
        clk_ena = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL oneshot_ovf: got %h want %h", o, e); end

        #2 rst_n = 1'b0;
        #1;
        q8.push_back('{cnt: 8'h00, run: 1'b1, ov: 1'b0, un: 1'b0});
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL async_rst: got %h want %h", o, e); end
        step();
        step();
        rst_n = 1'b1;

        mode    = 1'b1;
        up_down = 1'b0;
        clk_ena = 1'b1;
        q8.push_back('{cnt: 8'h5A, run: 1'b1, ov: 1'b0, un: 1'b1});
        step();
        clk_ena = 1'b0;
        e = q8.pop_front();
        o = {tcnt, running, overflow, underflow};
        total++;
        if (o !== e) begin bad++; $display("FAIL rst_reload: got %h want %h", o, e); end
    endtask

    task automatic test_compare();
        s16_t e;
        s16_t o;
        enable16  = 1'b1;
        up_down16 = 1'b1;
        mode16    = 1'b1;
        compare16 = 16'h0003;
        start16   = 16'h0000;
        load16    = 1'b1;
        q16.push_back('{cnt: 16'h0000, cm: 1'b0});
        step();
        load16 = 1'b0;
        e = q16.pop_front();
        o = {tcnt16, cmp_match16};
        total++;
        if (o !== e) begin bad++; $display("FAIL cmp_load0: got %h want %h", o, e); end

        clk_ena16 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            q16.push_back('{cnt: 16'(k), cm: CMP_ON & (k >= 4)});
            step();
            e = q16.pop_front();
            o = {tcnt16, cmp_match16};
            total++;
            if (o !== e) begin bad++; $display("FAIL cmp_tick%0d: got %h want %h", k, o, e); end
        end
        clk_ena16 = 1'b0;

        clr_cmp16 = 1'b1;
        q16.push_back('{cnt: 16'h0006, cm: 1'b0});
        step();
        clr_cmp16 = 1'b0;
        e = q16.pop_front();
        o = {tcnt16, cmp_match16};
        total++;
        if (o !== e) begin bad++; $display("FAIL cmp_clr: got %h want %h", o, e); end

        start16 = 16'h0003;
        load16  = 1'b1;
        q16.push_back('{cnt: 16'h0003, cm: 1'b0});
        q16.push_back('{cnt: 16'h0003, cm: CMP_ON});
        step();
        load16 = 1'b0;
        e = q16.pop_front();
        o = {tcnt16, cmp_match16};
        total++;
        if (o !== e) begin bad++; $display("FAIL cmp_ld_a: got %h want %h", o, e); end
        step();
        e = q16.pop_front();
        o = {tcnt16, cmp_match16};
        total++;
        if (o !== e) begin bad++; $display("FAIL cmp_ld_b: got %h want %h", o, e); end

        clr_cmp16 = 1'b1;
        step();
        clr_cmp16 = 1'b0;
        load16 = 1'b1;
        step();
        load16    = 1'b0;
        clr_cmp16 = 1'b1;
        q16.push_back('{cnt: 16'h0003, cm: CMP_ON});
        step();
        clr_cmp16 = 1'b0;
        e = q16.pop_front();
        o = {tcnt16, cmp_match16};
        total++;
        if (o !== e) begin bad++; $display("FAIL cmp_set_beats_clr: got %h want %h", o, e); end
    endtask

    initial begin
        test_reset();
        test_down_oneshot();
        test_flag_priority();
        test_up_reload();
        test_load_priority();
        test_compare();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_counter_n.md
Name: timer_counter_n

Overview:
- Parametrised N-bit timer/counter core. Next generation of the 8-bit Timer counter.
- Counts up or down on qualified ticks (`clk_ena` from the prescaler). Supports a one-shot mode, an auto-reload mode, and sticky overflow/underflow/compare flags with software clear.
- Sits between the prescaler/clock-select logic and the register interface. Internal count is visible through `tcnt`.

Parameters:
- WIDTH, 8, counter/data width in bits; minimum 2.
- RST_RELOAD, 0, reset value of the internal reload register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- clk_ena  in  1  one-clk-wide count qualifier from the prescaler.
- enable  in  1  count enable; ignored while low.
- up_down  in  1  direction: 1 = up, 0 = down.
- mode  in  1  wrap mode: 0 = one-shot, 1 = auto-reload.
- load  in  1  load `start_counter` into the count and the reload register.
- start_counter  in  WIDTH  load/reload value.
- compare_val  in  WIDTH  compare value (used only with TIMER_CMP_EN).
- clr_overflow  in  1  clear the overflow flag.
- clr_underflow  in  1  clear the underflow flag.
- clr_cmp  in  1  clear the compare flag.
- tcnt  out  WIDTH  current count.
- running  out  1  counter is armed (not halted by one-shot).
- overflow  out  1  sticky overflow flag.
- underflow  out  1  sticky underflow flag.
- cmp_match  out  1  sticky compare-match flag.

Behaviour:
- Reset (`rst_n` = 0, asynchronous):
  - `tcnt` = 0, reload register = RST_RELOAD.
  - `running` = 1, `overflow` = `underflow` = `cmp_match` = 0.
  - Reset mid-count discards all state immediately.
- Tick: a clk edge where `clk_ena` = 1, `enable` = 1, `running` = 1 and `load` = 0. Only ticks change `tcnt`.
- Load:
  - When `load` = 1: `tcnt` <= `start_counter`, reload <= `start_counter`, `running` <= 1, on the next clk edge. Independent of `clk_ena` and `enable`.
  - Load beats a tick in the same cycle.
  - Flags are not affected by load.
- Up tick:
  - `tcnt` < max: `tcnt` + 1.
  - `tcnt` = 2^WIDTH-1: set `overflow`. Auto-reload: `tcnt` <= reload. One-shot: `tcnt` <= 0 and `running` <= 0.
- Down tick:
  - `tcnt` > 0: `tcnt` - 1.
  - `tcnt` = 0: set `underflow`. Auto-reload: `tcnt` <= reload. One-shot: `tcnt` <= 2^WIDTH-1 and `running` <= 0.
- Timing: flags are registered and visible one clk after the wrapping tick edge. Latency from a `clk_ena` pulse to the new `tcnt` is 1 clk.
- Wrap count: down from N in auto-reload gives an underflow every N+1 ticks. Down from 255 (WIDTH = 8): 255 ticks to reach 0, the 256th tick sets `underflow`.
- Sticky flags: set stays until the matching clr is pulsed. Set and clear in the same cycle: set wins.
- `up_down` or `mode` change mid-count: takes effect on the next tick; no `tcnt` change at the switch.
- Halted (`running` = 0): `tcnt` holds. Only load or reset re-arms.
- `tcnt`, flags and `running` are all registered outputs; no combinational paths from inputs.

Optional Feature:
- Macro TIMER_CMP_EN.
- Defined:
  - After any tick or load edge, if the new `tcnt` equals `compare_val`, set `cmp_match` (visible the cycle after `tcnt` updates).
  - A load directly to `compare_val` also sets it.
  - Set/clear priority is the same as the other flags.
- Not defined: `cmp_match` tied 0; `compare_val` and `clr_cmp` ignored. Ports stay present so the interface is identical.

Decomposition:
- Package timer_pkg:
  - MODE_ONESHOT = 1'b0, MODE_RELOAD = 1'b1.
  - DIR_DOWN = 1'b0, DIR_UP = 1'b1.
  - Function returning the max value for WIDTH.
- Sub-module timer_sticky_flag:
  - One-bit set/clear register, set-dominant, async active-low reset.
  - Instantiated three times: overflow, underflow, compare.

Test Plan:
- Reset: hold `rst_n` low 5 clks, then release → `tcnt` = 0, all flags 0, `running` = 1.
- Down count, WIDTH = 8, one-shot: load 255, down, `clk_ena` every 2 clks →
  - no flags through 255 ticks;
  - 256th tick: `underflow` = 1 one clk later, `tcnt` = 255, `running` = 0;
  - further ticks leave `tcnt` = 255.
- Up count, auto-reload: load 250, up → 5th tick `tcnt` = 255; 6th tick `overflow` = 1 and `tcnt` = 250; repeats every 6 ticks.
- Flag priority: `underflow` set; pulse `clr_underflow` → 0 next clk. Pulse `clr_underflow` on the same edge as a new underflow → flag stays 1.
- Load priority: `load` = 1 with `start_counter` = 0x10 in the same cycle as a `clk_ena` tick → `tcnt` = 0x10, not incremented. Mid-count async reset → outputs 0 immediately, without a clk edge.
- TIMER_CMP_EN, WIDTH = 16: load 0x0000, up, `compare_val` = 0x0003 → `cmp_match` = 1 one clk after `tcnt` = 3. Without the macro, same stimulus → `cmp_match` stays 0.
